output_port_arbiter: RTL and testbench
======================================

// Module: output_port_arbiter
// PURPOSE
//   Per-output-port scheduler for the 5-port mesh router. Shares one output port among the
//   five input ports (N/E/S/W/local injection) with wormhole locking: round-robin arbitration
//   on head flits, then exclusive ownership until the owner's tail flit passes. Registers the
//   winning flit onto the output link and drives per-requester block back to the input ports.
// PARAMETERS
//   flitWidth     32  width of one flit in bits
//   numReq        5   number of requesters; port index 4 = local injection
//   reqIdxWidth   3   width of owner index, >= clog2(numReq)
//   timeoutCycles 64  owner-idle cycles before forced release (PACKET_TIMEOUT_EN only)
// PORTS
//   clk         in   1                  clock, rising edge
//   reset       in   1                  asynchronous, active-high reset
//   reqValid    in   numReq             requester i presents a flit
//   reqHead     in   numReq             flit of requester i is a head flit
//   reqTail     in   numReq             flit of requester i is a tail flit; head+tail = single-flit packet
//   reqFlit     in   numReq*flitWidth   flit of requester i at bits [i*flitWidth +: flitWidth]
//   outBlock    in   1                  downstream cannot accept; stalls this port
//   grant       out  numReq             one-hot, combinational: flit of requester i accepted this cycle
//   portBlock   out  numReq             reqValid & ~grant; requester must hold its flit
//   outFlit     out  flitWidth          registered output flit
//   outValid    out  1                  outFlit is valid
//   busy        out  1                  port locked to a packet (state LOCKED)
//   owner       out  reqIdxWidth        index of current/last owner
//   errTimeout  out  1                  1-cycle pulse on forced release; tied 0 without macro
// BEHAVIOUR
//   Reset (async, any time, including mid-packet): state=IDLE, owner=0, rrPtr=numReq-1,
//     outFlit=0, outValid=0, grant=0, errTimeout=0. A partial packet is dropped, no tail emitted.
//   States: IDLE, LOCKED.
//   IDLE: candidates = reqValid & reqHead. If outBlock=0 and any candidate: winner = first
//     candidate scanning rrPtr+1, rrPtr+2, ... modulo numReq. grant[winner]=1 same cycle.
//     If the winner's flit is also a tail: stay IDLE, rrPtr<=winner. Else: LOCKED, owner<=winner.
//     Non-head valid flits in IDLE are never granted (held via portBlock).
//   LOCKED: only owner is eligible. grant[owner] = reqValid[owner] & ~outBlock. On a granted
//     tail flit: IDLE, rrPtr<=owner. Other requesters see portBlock=reqValid.
//   Output register: if outBlock=1, outFlit/outValid hold their values. Otherwise
//     outValid<=|grant and outFlit<=granted flit when |grant, else outFlit holds.
//     Latency: request to outFlit is 1 cycle. Throughput: 1 flit/cycle while unblocked.
//   outBlock=1 forces grant=0 in both states. A packet may be stalled indefinitely.
//   Head+tail arriving in the same cycle from one requester: handled as a single-flit packet.
//   rrPtr wraps from numReq-1 to 0. No requester starves: each packet completion moves priority
//     past the finishing owner.
//   busy = (state==LOCKED). owner keeps its last value in IDLE.
// CONFIGURATION
//   PACKET_TIMEOUT_EN defined: idle counter (clog2(timeoutCycles)+1 bits) clears on every
//     owner grant and on entry to LOCKED. It increments each LOCKED cycle with reqValid[owner]=0
//     and outBlock=0; cycles with outBlock=1 do not count. On reaching timeoutCycles: IDLE,
//     rrPtr<=owner, errTimeout pulses 1 cycle, and no flit is emitted that cycle.
//   PACKET_TIMEOUT_EN undefined: no counter; LOCKED exits only on a tail; errTimeout=0.
// TESTING
//   Reset: hold reset 3 cycles -> outValid=0, busy=0, grant=0, rrPtr=4, so port 0 has priority next.
//   Contention: ports 0,2,4 send a head plus 2 bodies plus a tail at once -> order 0,2,4; flits
//     contiguous per packet; outValid high 12 consecutive cycles.
//   Single-flit: port 3 sends head+tail flit 0xA5A5_0003 -> grant[3] that cycle; next cycle
//     outFlit=0xA5A5_0003, outValid=1; busy stays 0.
//   Backpressure: outBlock=1 for 4 cycles mid-packet -> grant=0, outFlit/outValid hold;
//     resumes with the next body flit and no flit is lost or duplicated.
//   Locking: port 1 owns the port and port 0 presents a head -> portBlock[0]=1 until port 1's
//     tail is granted; port 0 is granted the following cycle.
//   Timeout (macro on, timeoutCycles=64): owner stops after its head -> errTimeout pulses after
//     64 idle cycles, busy=0, and a pending head is granted the next cycle.

Source files
------------

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin wormhole arbiter sharing one router output port among five inputs
// Optional forced release of a stalled owner is enabled by defining PACKET_TIMEOUT_EN.
module output_port_arbiter #(
    parameter int FLIT_WIDTH     = 32,
    parameter int NUM_REQ        = 5,
    parameter int REQ_IDX_WIDTH  = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_head,
    input  logic [NUM_REQ-1:0]            i_req_tail,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] i_req_flit,
    input  logic                          i_out_block,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_port_block,
    output logic [FLIT_WIDTH-1:0]         o_out_flit,
    output logic                          o_out_valid,
    output logic                          o_busy,
    output logic [REQ_IDX_WIDTH-1:0]      o_owner,
    output logic                          o_err_timeout
);

    if (REQ_IDX_WIDTH < $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("output_port_arbiter: invalid parameter set");
    end

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                   r_state, w_next_state;
    logic [REQ_IDX_WIDTH-1:0] r_owner, r_rr_ptr;
    logic [REQ_IDX_WIDTH-1:0] w_next_owner, w_next_rr, w_winner, w_sel;
    logic [NUM_REQ-1:0]       w_cand;
    logic                     w_found;
    logic                     w_timeout_hit;
    int                       w_idx;

    assign w_cand = i_req_valid & i_req_head;

    // First head-flit candidate after the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && w_cand[w_idx]) begin
                w_found  = 1'b1;
                w_winner = REQ_IDX_WIDTH'(w_idx);
            end
        end
    end

`ifdef PACKET_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] r_idle_cnt;

    assign w_timeout_hit = (r_state == S_LOCKED) && (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Counter stays cleared outside LOCKED, so entry to LOCKED always starts from zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idle_cnt <= '0;
        end else if (r_state != S_LOCKED || w_timeout_hit || o_grant[r_owner]) begin
            r_idle_cnt <= '0;
        end else if (!i_req_valid[r_owner] && !i_out_block) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_rr    = r_rr_ptr;
        w_sel        = r_owner;
        o_grant      = '0;
        if (!i_reset) begin
            case (r_state)
                S_IDLE: begin
                    if (!i_out_block && w_found) begin
                        o_grant[w_winner] = 1'b1;
                        w_sel             = w_winner;
                        if (i_req_tail[w_winner]) begin
                            w_next_rr = w_winner;
                        end else begin
                            w_next_state = S_LOCKED;
                            w_next_owner = w_winner;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_timeout_hit) begin
                        w_next_state = S_IDLE;
                        w_next_rr    = r_owner;
                    end else if (i_req_valid[r_owner] && !i_out_block) begin
                        o_grant[r_owner] = 1'b1;
                        if (i_req_tail[r_owner]) begin
                            w_next_state = S_IDLE;
                            w_next_rr    = r_owner;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= REQ_IDX_WIDTH'(NUM_REQ - 1);
            o_out_flit  <= '0;
            o_out_valid <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_owner  <= w_next_owner;
            r_rr_ptr <= w_next_rr;
            if (!i_out_block) begin
                o_out_valid <= |o_grant;
                if (|o_grant) begin
                    o_out_flit <= i_req_flit[w_sel*FLIT_WIDTH +: FLIT_WIDTH];
                end
            end
        end
    end

    assign o_port_block  = i_req_valid & ~o_grant;
    assign o_busy        = (r_state == S_LOCKED);
    assign o_owner       = r_owner;
    assign o_err_timeout = w_timeout_hit;

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - directed vector bench for output_port_arbiter
module tb_output_port_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   req_valid, req_head, req_tail;
    logic [159:0] req_flit;
    logic         out_block;
    logic [4:0]   grant, port_block;
    logic [31:0]  out_flit;
    logic         out_valid, busy, err_timeout;
    logic [2:0]   owner;

    int n_cmp = 0;
    int n_err = 0;

    output_port_arbiter dut (
        .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .i_req_head(req_head),
        .i_req_tail(req_tail), .i_req_flit(req_flit), .i_out_block(out_block),
        .o_grant(grant), .o_port_block(port_block), .o_out_flit(out_flit),
        .o_out_valid(out_valid), .o_busy(busy), .o_owner(owner), .o_err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  v, h, t;
        logic        b;
        logic [31:0] base;
        logic [4:0]  eg, epb;
        logic        ebusy;
        logic [2:0]  eown;
        logic        eov;
        logic [31:0] eof;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                         input logic b, input logic [31:0] base);
        req_valid = v;
        req_head  = h;
        req_tail  = t;
        out_block = b;
        for (int p = 0; p < 5; p++) req_flit[p*32 +: 32] = base + 32'(p);
    endtask

    task automatic do_reset();
        drive(5'b0, 5'b0, 5'b0, 1'b0, 32'h0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_out_flit", out_flit, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] cflit(input int p, input int pos);
        return 32'hC000_0000 | (32'(p) << 16) | 32'(pos);
    endfunction

    // Ports 0, 2 and 4 each send head, two bodies and a tail at once; optional block window.
    task automatic contention(input int blk_start, input int blk_len);
        int          pos[5];
        int          order[3];
        int          pk;
        int          cyc;
        int          run;
        logic        b;
        logic [4:0]  eg;
        logic        exp_ov;
        logic [31:0] exp_of;
        order  = '{0, 2, 4};
        pos    = '{0, 0, 0, 0, 0};
        pk     = 0;
        cyc    = 0;
        run    = 0;
        exp_ov = 1'b0;
        exp_of = 32'h0;
        while (pk < 3 && cyc < 40) begin
            @(negedge clk);
            b = (cyc >= blk_start) && (cyc < blk_start + blk_len);
            req_valid = '0; req_head = '0; req_tail = '0; out_block = b;
            req_flit  = '0;
            for (int i = 0; i < 3; i++) begin
                if (pos[order[i]] < 4) begin
                    req_valid[order[i]] = 1'b1;
                    req_head[order[i]]  = (pos[order[i]] == 0);
                    req_tail[order[i]]  = (pos[order[i]] == 3);
                    req_flit[order[i]*32 +: 32] = cflit(order[i], pos[order[i]]);
                end
            end
            eg = b ? 5'b0 : 5'(1 << order[pk]);
            #2;
            chk("cont_grant", 32'(grant), 32'(eg));
            @(posedge clk);
            #1;
            if (!b) begin
                exp_ov = 1'b1;
                exp_of = cflit(order[pk], pos[order[pk]]);
                pos[order[pk]]++;
                if (pos[order[pk]] == 4) pk++;
            end
            chk("cont_out_valid", 32'(out_valid), 32'(exp_ov));
            chk("cont_out_flit", out_flit, exp_of);
            if (out_valid) run++;
            cyc++;
        end
        chk("cont_done", 32'(pk), 32'd3);
        @(negedge clk);
        drive(5'b0, 5'b0, 5'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("cont_end_valid", 32'(out_valid), 32'h0);
        if (blk_len == 0) chk("cont_valid_run", 32'(run), 32'd12);
    endtask

    task automatic step(input string name, input logic [4:0] v, input logic [4:0] h,
                        input logic [4:0] t, input logic [4:0] eg, input logic [4:0] epb,
                        input logic ebusy);
        @(negedge clk);
        drive(v, h, t, 1'b0, 32'h0D0D_0000);
        #2;
        chk({name, "_grant"}, 32'(grant), 32'(eg));
        chk({name, "_pblk"}, 32'(port_block), 32'(epb));
        chk({name, "_busy"}, 32'(busy), 32'(ebusy));
    endtask

    initial begin
        reset = 1'b1;
        drive(5'b0, 5'b0, 5'b0, 1'b0, 32'h0);

        tbl[0]  = '{5'b01000, 5'b01000, 5'b01000, 1'b0, 32'hA5A5_0000, 5'b01000, 5'b00000, 1'b0, 3'd0, 1'b1, 32'hA5A5_0003};
        tbl[1]  = '{5'b00000, 5'b00000, 5'b00000, 1'b0, 32'h0B0B_0100, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 32'hA5A5_0003};
        tbl[2]  = '{5'b00010, 5'b00000, 5'b00000, 1'b0, 32'h0B0B_0200, 5'b00000, 5'b00010, 1'b0, 3'd0, 1'b0, 32'hA5A5_0003};
        tbl[3]  = '{5'b10010, 5'b10010, 5'b00000, 1'b0, 32'h0B0B_0300, 5'b10000, 5'b00010, 1'b0, 3'd0, 1'b1, 32'h0B0B_0304};
        tbl[4]  = '{5'b10010, 5'b00010, 5'b00000, 1'b1, 32'h0B0B_0400, 5'b00000, 5'b10010, 1'b1, 3'd4, 1'b1, 32'h0B0B_0304};
        tbl[5]  = '{5'b10010, 5'b00010, 5'b10000, 1'b0, 32'h0B0B_0500, 5'b10000, 5'b00010, 1'b1, 3'd4, 1'b1, 32'h0B0B_0504};
        tbl[6]  = '{5'b00011, 5'b00011, 5'b00010, 1'b0, 32'h0B0B_0600, 5'b00001, 5'b00010, 1'b0, 3'd4, 1'b1, 32'h0B0B_0600};
        tbl[7]  = '{5'b00010, 5'b00010, 5'b00010, 1'b0, 32'h0B0B_0700, 5'b00000, 5'b00010, 1'b1, 3'd0, 1'b0, 32'h0B0B_0600};
        tbl[8]  = '{5'b00011, 5'b00010, 5'b00011, 1'b0, 32'h0B0B_0800, 5'b00001, 5'b00010, 1'b1, 3'd0, 1'b1, 32'h0B0B_0800};
        tbl[9]  = '{5'b00010, 5'b00010, 5'b00010, 1'b0, 32'h0B0B_0900, 5'b00010, 5'b00000, 1'b0, 3'd0, 1'b1, 32'h0B0B_0901};
        tbl[10] = '{5'b00100, 5'b00100, 5'b00000, 1'b1, 32'h0B0B_0A00, 5'b00000, 5'b00100, 1'b0, 3'd0, 1'b1, 32'h0B0B_0901};
        tbl[11] = '{5'b00000, 5'b00000, 5'b00000, 1'b0, 32'h0B0B_0B00, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 32'h0B0B_0901};

        do_reset();
        contention(-100, 0);
        do_reset();
        contention(5, 4);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].h, tbl[i].t, tbl[i].b, tbl[i].base);
            #2;
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].eg));
            chk($sformatf("vec%0d_pblk", i), 32'(port_block), 32'(tbl[i].epb));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].ebusy));
            chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(tbl[i].eown));
            chk($sformatf("vec%0d_err", i), 32'(err_timeout), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
            chk($sformatf("vec%0d_out_flit", i), out_flit, tbl[i].eof);
        end

        do_reset();
        step("lock_c1", 5'b00010, 5'b00010, 5'b00000, 5'b00010, 5'b00000, 1'b0);
        step("lock_c2", 5'b00011, 5'b00001, 5'b00000, 5'b00010, 5'b00001, 1'b1);
        step("lock_c3", 5'b00011, 5'b00001, 5'b00010, 5'b00010, 5'b00001, 1'b1);
        step("lock_c4", 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 1'b0);
        step("lock_c5", 5'b00100, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 1'b0);
        @(negedge clk);
        drive(5'b00100, 5'b00100, 5'b00000, 1'b0, 32'h0E0E_0000);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_out_valid", 32'(out_valid), 32'h0);
        chk("async_rst_grant", 32'(grant), 32'h0);
        chk("async_rst_owner", 32'(owner), 32'h0);

        do_reset();
        step("to_head", 5'b00001, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 1'b0);
`ifdef PACKET_TIMEOUT_EN
        for (int i = 0; i < 64; i++) begin
            step("to_wait", 5'b01000, 5'b01000, 5'b01000, 5'b00000, 5'b01000, 1'b1);
            chk("to_wait_err", 32'(err_timeout), 32'h0);
        end
        step("to_fire", 5'b01000, 5'b01000, 5'b01000, 5'b00000, 5'b01000, 1'b1);
        chk("to_fire_err", 32'(err_timeout), 32'h1);
        @(posedge clk);
        #1;
        chk("to_fire_no_flit", 32'(out_valid), 32'h0);
        step("to_after", 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b00000, 1'b0);
        chk("to_after_err", 32'(err_timeout), 32'h0);
`else
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            drive(5'b01000, 5'b01000, 5'b01000, 1'b0, 32'h0F0F_0000);
        end
        #2;
        chk("stall_busy", 32'(busy), 32'h1);
        chk("stall_grant", 32'(grant), 32'h0);
        chk("stall_err", 32'(err_timeout), 32'h0);
        chk("stall_pblk", 32'(port_block), 32'h8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
